// File: rtl/ledr_write_arbiter_pkg.sv
// Shared definitions for the red-LED PIO write arbiter: state encoding,
// PIO register map and LED pattern width.
package ledr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      HOLD  = 2'd2
   } ledr_state_e;

   localparam logic [1:0] LEDR_ADDR_DATA = 2'd0;
   localparam int         LEDR_WIDTH     = 10;

endpackage

// File: rtl/ledr_write_arbiter_rr_arbiter.sv
// Combinational round-robin priority select. The requester just after
// 'last' has highest priority, wrapping around to 'last' itself.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last,
   output logic [NUM_REQ-1:0] grant_oh,
   output logic [ID_W-1:0]    grant_idx,
   output logic               grant_vld
);

   // Two ascending passes: first the indices above 'last', then from 0 up.
   always_comb begin
      logic found;
      found     = 1'b0;
      grant_oh  = '0;
      grant_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i] && (i > int'(last))) begin
            found       = 1'b1;
            grant_oh[i] = 1'b1;
            grant_idx   = ID_W'(i);
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[i]) begin
            found       = 1'b1;
            grant_oh[i] = 1'b1;
            grant_idx   = ID_W'(i);
         end
      end
      grant_vld = found;
   end

endmodule

// File: rtl/ledr_write_arbiter.sv
// Shares the red-LED PIO slave among NUM_REQ requesters. Each grant becomes
// one single-cycle Avalon write to the data register, followed by a hold
// interval that keeps the new pattern visible before the next grant.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for any req; grants round-robin and loads the bus
//   WRITE | chipselect/write strobe and ack asserted for one cycle
//   HOLD  | down-counter runs to zero; requests ignored
module ledr_write_arbiter
   import ledr_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = LEDR_WIDTH,
   parameter int HOLD_CYCLES = 25000000,
   parameter int HOLD_W      = 25,
   parameter int ID_W        = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [ID_W-1:0]           grant_id,
   output logic                      busy,
   output logic [1:0]                pio_address,
   output logic                      pio_chipselect,
   output logic                      pio_write_n,
   output logic [31:0]               pio_writedata
);

   localparam logic [HOLD_W-1:0] HOLD_LOAD =
      (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;
   localparam logic [ID_W-1:0]   LAST_RST  = ID_W'(NUM_REQ - 1);

   ledr_state_e         state_q, state_d;
   logic [ID_W-1:0]     last_q, last_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [HOLD_W-1:0]   cnt_q, cnt_d;
   logic [NUM_REQ-1:0]  ack_q, ack_d;
   logic                busy_q, busy_d;
   logic                cs_q, cs_d;
   logic                wn_q, wn_d;
   logic [31:0]         wd_q, wd_d;

   logic [NUM_REQ-1:0]  grant_oh;
   logic [ID_W-1:0]     grant_idx;
   logic                grant_vld;
   logic [DATA_W-1:0]   sel_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .req       (req),
      .last      (last_q),
      .grant_oh  (grant_oh),
      .grant_idx (grant_idx),
      .grant_vld (grant_vld)
   );

   // Pick the granted requester's pattern out of the flattened data bus.
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) begin
            sel_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Next-state, hold timer and next values of the registered bus outputs.
   // The bus strobe and ack are loaded on the IDLE grant edge so that they
   // are high exactly while the FSM sits in WRITE.
   always_comb begin
      state_d    = state_q;
      last_d     = last_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q;
      ack_d      = '0;
      cs_d       = 1'b0;
      wn_d       = 1'b1;
      wd_d       = wd_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_d    = WRITE;
               last_d     = grant_idx;
               grant_id_d = grant_idx;
               ack_d      = grant_oh;
               cs_d       = 1'b1;
               wn_d       = 1'b0;
               wd_d       = 32'(sel_data);
            end
         end
         WRITE: begin
            if (HOLD_CYCLES > 0) begin
               state_d = HOLD;
               cnt_d   = HOLD_LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - HOLD_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State, pointer, timer and bus registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         last_q     <= LAST_RST;
         grant_id_q <= '0;
         cnt_q      <= '0;
         ack_q      <= '0;
         busy_q     <= 1'b0;
         cs_q       <= 1'b0;
         wn_q       <= 1'b1;
         wd_q       <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         grant_id_q <= grant_id_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         busy_q     <= busy_d;
         cs_q       <= cs_d;
         wn_q       <= wn_d;
         wd_q       <= wd_d;
      end
   end

   assign ack            = ack_q;
   assign grant_id       = grant_id_q;
   assign busy           = busy_q;
   assign pio_address    = LEDR_ADDR_DATA;
   assign pio_chipselect = cs_q;
   assign pio_write_n    = wn_q;
   assign pio_writedata  = wd_q;

endmodule

// File: tb/tb_ledr_write_arbiter.sv
// Directed bench for ledr_write_arbiter: one instance with a 3-cycle hold
// interval and one with no hold interval.
module tb_ledr_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req;
   logic [39:0] req_data;
   logic [3:0]  ack;
   logic [1:0]  grant_id;
   logic        busy;
   logic [1:0]  pio_address;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [31:0] pio_writedata;

   logic [3:0]  req0;
   logic [39:0] req_data0;
   logic [3:0]  ack0;
   logic [1:0]  grant_id0;
   logic        busy0;
   logic [1:0]  pio_address0;
   logic        pio_chipselect0;
   logic        pio_write_n0;
   logic [31:0] pio_writedata0;

   int checks = 0;
   int errors = 0;

   ledr_write_arbiter #(
      .NUM_REQ(4), .DATA_W(10), .HOLD_CYCLES(3), .HOLD_W(2), .ID_W(2)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data),
      .ack(ack), .grant_id(grant_id), .busy(busy),
      .pio_address(pio_address), .pio_chipselect(pio_chipselect),
      .pio_write_n(pio_write_n), .pio_writedata(pio_writedata)
   );

   ledr_write_arbiter #(
      .NUM_REQ(4), .DATA_W(10), .HOLD_CYCLES(0), .HOLD_W(1), .ID_W(2)
   ) dut0 (
      .clk(clk), .reset(reset), .req(req0), .req_data(req_data0),
      .ack(ack0), .grant_id(grant_id0), .busy(busy0),
      .pio_address(pio_address0), .pio_chipselect(pio_chipselect0),
      .pio_write_n(pio_write_n0), .pio_writedata(pio_writedata0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Bus view of the HOLD_CYCLES=3 instance, packed for one compare:
   // {chipselect, write_n, busy, ack}
   function automatic logic [31:0] bus();
      return {25'd0, pio_chipselect, pio_write_n, busy, ack};
   endfunction

   function automatic logic [31:0] bus0();
      return {25'd0, pio_chipselect0, pio_write_n0, busy0, ack0};
   endfunction

   // Expected write cycle: cs=1, wn=0, busy=1, ack one-hot.
   function automatic logic [31:0] wr_exp(input logic [3:0] a);
      return {25'd0, 1'b1, 1'b0, 1'b1, a};
   endfunction

   // Expected non-write cycle: cs=0, wn=1, no ack.
   function automatic logic [31:0] nw_exp(input logic b);
      return {25'd0, 1'b0, 1'b1, b, 4'b0000};
   endfunction

   task automatic check_write(input string tag, input logic [3:0] a,
                              input logic [1:0] gid, input logic [31:0] wd);
      chk({tag, "_bus"}, bus(), wr_exp(a));
      chk({tag, "_gid"}, {30'd0, grant_id}, {30'd0, gid});
      chk({tag, "_wd"}, pio_writedata, wd);
   endtask

   // Four cycles after a write: WRITE->HOLD, HOLD x2, HOLD->IDLE.
   task automatic check_hold(input string tag);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk(tag, bus(), nw_exp(k != 4));
      end
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_idle_timeout"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [3:0]  rr_ack [4];
      logic [31:0] rr_wd  [4];
      rr_ack[0] = 4'b0001; rr_ack[1] = 4'b0010; rr_ack[2] = 4'b0100; rr_ack[3] = 4'b1000;
      rr_wd[0]  = 32'h001; rr_wd[1]  = 32'h002; rr_wd[2]  = 32'h004; rr_wd[3]  = 32'h008;

      reset     = 1'b1;
      req       = 4'b1111;
      req_data  = {10'h008, 10'h004, 10'h002, 10'h001};
      req0      = 4'b0000;
      req_data0 = {10'h000, 10'h000, 10'h155, 10'h000};

      // Reset with all requests high: nothing written, reset values held.
      for (int c = 0; c < 3; c++) begin
         step();
         chk("rst_bus", bus(), nw_exp(1'b0));
         chk("rst_gid", {30'd0, grant_id}, 32'd0);
         chk("rst_wd", pio_writedata, 32'd0);
         chk("rst_addr", {30'd0, pio_address}, 32'd0);
      end
      reset = 1'b0;

      // All four requesting: 0,1,2,3,0 each exactly 5 cycles apart.
      for (int w = 0; w < 5; w++) begin
         step();
         check_write("rr", rr_ack[w % 4], 2'(w % 4), rr_wd[w % 4]);
         if (w == 4) req = 4'b0000;
         check_hold("rr_hold");
      end
      chk("rr_idle_wd_hold", pio_writedata, 32'h001);

      // Single request from requester 2, released after its ack.
      req_data[20 +: 10] = 10'h2AA;
      req = 4'b0100;
      step();
      check_write("single", 4'b0100, 2'd2, 32'h0000_02AA);
      chk("single_addr", {30'd0, pio_address}, 32'd0);
      req = 4'b0000;
      check_hold("single_hold");
      step();
      chk("single_no_rewrite", bus(), nw_exp(1'b0));

      // Fairness: req0 held high, req2 pulsed until acked (pointer at 2).
      req_data[0 +: 10]  = 10'h0F0;
      req_data[20 +: 10] = 10'h30F;
      req = 4'b0101;
      step();
      check_write("fair_a", 4'b0001, 2'd0, 32'h0F0);
      check_hold("fair_a_hold");
      step();
      check_write("fair_b", 4'b0100, 2'd2, 32'h30F);
      req = 4'b0001;
      check_hold("fair_b_hold");
      step();
      check_write("fair_c", 4'b0001, 2'd0, 32'h0F0);
      req = 4'b0101;
      check_hold("fair_c_hold");
      step();
      check_write("fair_d", 4'b0100, 2'd2, 32'h30F);
      req = 4'b0000;
      wait_idle("fair");

      // Reset during HOLD: outputs idle next cycle, pointer back to 3.
      req_data[10 +: 10] = 10'h111;
      req = 4'b0010;
      step();
      check_write("rh_pre", 4'b0010, 2'd1, 32'h111);
      req = 4'b0000;
      step();
      step();
      reset = 1'b1;
      step();
      chk("rh_bus", bus(), nw_exp(1'b0));
      chk("rh_gid", {30'd0, grant_id}, 32'd0);
      chk("rh_wd", pio_writedata, 32'd0);
      reset = 1'b0;
      req = 4'b1111;
      req_data = {10'h008, 10'h004, 10'h002, 10'h001};
      step();
      check_write("rh_restart", 4'b0001, 2'd0, 32'h001);

      // Reset coinciding with WRITE: strobe and ack drop, no further write.
      reset = 1'b1;
      step();
      chk("rw_bus", bus(), nw_exp(1'b0));
      chk("rw_wd", pio_writedata, 32'd0);
      step();
      chk("rw_bus2", bus(), nw_exp(1'b0));
      reset = 1'b0;
      step();
      check_write("rw_restart", 4'b0001, 2'd0, 32'h001);
      req = 4'b0000;
      wait_idle("rw");

      // No hold interval: continuous req1 gets a write every 2 cycles.
      req0 = 4'b0010;
      for (int w = 0; w < 3; w++) begin
         step();
         chk("h0_write", bus0(), wr_exp(4'b0010));
         chk("h0_wd", pio_writedata0, 32'h155);
         chk("h0_gid", {30'd0, grant_id0}, 32'd1);
         step();
         chk("h0_gap", bus0(), nw_exp(1'b0));
      end
      req0 = 4'b0000;
      step();
      step();
      chk("h0_stop", bus0(), nw_exp(1'b0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
